// File: rtl/fx_kpad_responder_pkg.sv
// Shared types and constants for the PC-FX K-port joypad responder.
package fx_kpad_pkg;

    localparam int KPAD_WORD_W = 32;
    localparam int ID_MSB      = 31;
    localparam int ID_LSB      = 28;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2
    } kpad_state_e;

    localparam int BTN_I      = 0;
    localparam int BTN_II     = 1;
    localparam int BTN_III    = 2;
    localparam int BTN_IV     = 3;
    localparam int BTN_V      = 4;
    localparam int BTN_VI     = 5;
    localparam int BTN_SELECT = 6;
    localparam int BTN_RUN    = 7;
    localparam int BTN_UP     = 8;
    localparam int BTN_RIGHT  = 9;
    localparam int BTN_DOWN   = 10;
    localparam int BTN_LEFT   = 11;
    localparam int BTN_MODE1  = 12;
    localparam int BTN_MODE2  = 14;

    // An absent pad answers with an all-zero word so the host reads "nothing connected".
    function automatic logic [KPAD_WORD_W-1:0] pad_word(input logic [3:0]  id,
                                                        input logic        present,
                                                        input logic [15:0] btn);
        logic [KPAD_WORD_W-1:0] w;
        w = '0;
        if (present) begin
            w[ID_MSB:ID_LSB] = id;
            w[15:0]          = btn;
        end
        return w;
    endfunction

endpackage

// File: rtl/fx_kpad_responder_if.sv
// K-port pin bundle between the KPC (master) and a device (slave).
interface fx_kpad_responder_if;
    logic KP_LATCH;
    logic KP_CLK;
    logic KP_DI;
    logic KP_DO;

    modport master (output KP_LATCH, output KP_CLK, output KP_DI, input KP_DO);
    modport slave  (input KP_LATCH, input KP_CLK, input KP_DI, output KP_DO);
endinterface

// File: rtl/fx_kpad_responder_edge.sv
// CE-gated input register with rise/fall detection on the registered level.
module fx_kpad_edge (
    input  logic CLK,
    input  logic RES,
    input  logic CE,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic prev;

    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) begin
                level <= 1'b0;
                prev  <= 1'b0;
            end else begin
                prev  <= level;
                level <= d;
            end
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;
endmodule

// File: rtl/fx_kpad_responder.sv
// PC-FX K-port joypad responder: latch a pad word, shift it out LSB-first on KP_CLK.
// Optional receive path enabled by defining FX_KPAD_RX_EN.
//
// state  | meaning
// IDLE   | no transfer, KP_DO held high
// LOADED | KP_LATCH high, pad word reloaded each CE, KP_DO = bit 0
// SHIFT  | shifting one bit per KP_CLK rise, timeout running
module fx_kpad_responder
    import fx_kpad_pkg::*;
#(
    parameter logic [3:0] PAD_ID      = 4'hF,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic                   CLK,
    input  logic                   RES,
    input  logic                   CE,
    fx_kpad_responder_if.slave     kp,
    input  logic                   PRESENT,
    input  logic [15:0]            BTN,
    output logic                   BUSY,
    output logic [KPAD_WORD_W-1:0] RX_DATA,
    output logic                   RX_VALID
);
    localparam int              TW     = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [1:0]      S_IDLE   = IDLE;
    localparam logic [1:0]      S_LOADED = LOADED;
    localparam logic [1:0]      S_SHIFT  = SHIFT;

    logic [1:0]             state;
    logic [5:0]             bcnt;
    logic [TW-1:0]          tcnt;
    logic [KPAD_WORD_W-1:0] shreg;
    logic [KPAD_WORD_W-1:0] shift_in;
    logic                   lat_level, lat_rise, lat_fall;
    logic                   clk_level, clk_rise, clk_fall;
    logic                   last_rise;
    logic                   unused_clk_edge;

    fx_kpad_edge u_lat_edge (
        .CLK(CLK), .RES(RES), .CE(CE), .d(kp.KP_LATCH),
        .level(lat_level), .rise(lat_rise), .fall(lat_fall)
    );

    fx_kpad_edge u_clk_edge (
        .CLK(CLK), .RES(RES), .CE(CE), .d(kp.KP_CLK),
        .level(clk_level), .rise(clk_rise), .fall(clk_fall)
    );

    assign unused_clk_edge = clk_level ^ clk_fall;

    assign shift_in  = {kp.KP_DI, shreg[KPAD_WORD_W-1:1]};
    assign last_rise = !lat_rise && (state == S_SHIFT) && clk_rise && (bcnt == 6'd31);

    // A latch rise outranks everything else, including a coincident KP_CLK rise.
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) begin
                state <= S_IDLE;
                bcnt  <= '0;
                tcnt  <= '0;
                shreg <= '0;
            end else if (lat_rise) begin
                state <= S_LOADED;
                shreg <= pad_word(PAD_ID, PRESENT, BTN);
                bcnt  <= '0;
                tcnt  <= '0;
            end else begin
                case (state)
                    S_LOADED: begin
                        if (lat_fall) begin
                            state <= S_SHIFT;
                            bcnt  <= '0;
                            tcnt  <= '0;
                        end else if (lat_level) begin
                            shreg <= pad_word(PAD_ID, PRESENT, BTN);
                        end
                    end
                    S_SHIFT: begin
                        if (clk_rise) begin
                            shreg <= shift_in;
                            tcnt  <= '0;
                            if (bcnt != 6'd32) bcnt <= bcnt + 6'd1;
                            if (bcnt == 6'd31) state <= S_IDLE;
                        end else if (tcnt == T_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    S_IDLE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign BUSY      = (state == S_LOADED) || (state == S_SHIFT);
    assign kp.KP_DO  = BUSY ? shreg[0] : 1'b1;

`ifdef FX_KPAD_RX_EN
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) begin
                RX_DATA  <= '0;
                RX_VALID <= 1'b0;
            end else begin
                RX_VALID <= last_rise;
                if (last_rise) RX_DATA <= shift_in;
            end
        end
    end
`else
    logic unused_rx;
    assign unused_rx = last_rise;
    assign RX_DATA   = '0;
    assign RX_VALID  = 1'b0;
`endif

endmodule

// File: tb/tb_fx_kpad_responder.sv
// Directed-plus-random bench for fx_kpad_responder; expectations come from a word-level model.
module tb_fx_kpad_responder;

    localparam int TIMEOUT_CYC = 4096;
    localparam int HOST_LOW    = 2;   // host idle cycles after each clock pulse
`ifdef FX_KPAD_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RES = 1'b0;
    logic        CE  = 1'b1;
    logic        PRESENT = 1'b0;
    logic [15:0] BTN = 16'h0;
    logic        BUSY;
    logic [31:0] RX_DATA;
    logic        RX_VALID;

    int vectors    = 0;
    int miscompares = 0;
    int rx_pulses  = 0;

    fx_kpad_responder_if kp ();

    fx_kpad_responder #(.PAD_ID(4'hF), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .CLK(CLK), .RES(RES), .CE(CE), .kp(kp),
        .PRESENT(PRESENT), .BTN(BTN), .BUSY(BUSY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (RX_VALID === 1'b1) rx_pulses++;

    function automatic logic [31:0] model_word(input logic present, input logic [15:0] btn);
        return present ? ((32'hF << 28) | 32'(btn)) : 32'h0;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clk_bit(input logic di);
        kp.KP_DI  = di;
        kp.KP_CLK = 1'b1;
        tick(2);
        kp.KP_CLK = 1'b0;
        tick(HOST_LOW);
    endtask

    task automatic do_latch(input bit clk_in_loaded);
        kp.KP_LATCH = 1'b1;
        tick(3);
        if (clk_in_loaded) clk_bit(1'b1);
        kp.KP_LATCH = 1'b0;
        tick(3);
    endtask

    // Reads bits [first, first+n) sampling KP_DO before each rise.
    task automatic read_bits(input int first, input int n, input logic [31:0] di_w,
                             input bit mutate, inout logic [31:0] got);
        for (int i = first; i < first + n; i++) begin
            if (mutate && i == 8) begin
                BTN     = 16'($urandom);
                PRESENT = 1'($urandom);
            end
            got[i] = kp.KP_DO;
            clk_bit(di_w[i]);
        end
    endtask

    task automatic xfer(input string tag, input logic [31:0] di_w,
                        input bit clk_in_loaded, input bit mutate);
        logic [31:0] exp, got;
        int p0;
        exp = model_word(PRESENT, BTN);
        got = '0;
        p0  = rx_pulses;
        do_latch(clk_in_loaded);
        chk({tag, "_busy_shift"}, 32'(BUSY), 32'd1);
        read_bits(0, 32, di_w, mutate, got);
        chk({tag, "_word"}, got, exp);
        chk({tag, "_busy_end"}, 32'(BUSY), 32'd0);
        chk({tag, "_do_idle"}, 32'(kp.KP_DO), 32'd1);
        chk_int({tag, "_rx_pulses"}, rx_pulses - p0, RX_EN ? 1 : 0);
        chk({tag, "_rx_data"}, RX_DATA, RX_EN ? di_w : 32'h0);
    endtask

    initial begin
        logic [31:0] got, exp1, exp2, di_w;
        int p0;

        kp.KP_LATCH = 1'b0;
        kp.KP_CLK   = 1'b0;
        kp.KP_DI    = 1'b0;

        RES = 1'b1;
        tick(2);
        RES = 1'b0;
        tick(1);
        chk("rst_do",       32'(kp.KP_DO), 32'd1);
        chk("rst_busy",     32'(BUSY),     32'd0);
        chk("rst_rx_data",  RX_DATA,       32'h0);
        chk("rst_rx_valid", 32'(RX_VALID), 32'd0);

        PRESENT = 1'b1; BTN = 16'h0081;
        xfer("t1", $urandom, 1'b0, 1'b0);
        PRESENT = 1'b0; BTN = 16'($urandom);
        xfer("t2", $urandom, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            PRESENT = 1'($urandom);
            BTN     = 16'($urandom);
            if (k[0]) clk_bit(1'b1);          // KP_CLK rise in IDLE must be ignored
            xfer($sformatf("rnd%0d", k), $urandom, k[1], 1'b1);
        end

        // Re-latch mid-word, with the latch rise coincident with a KP_CLK rise.
        PRESENT = 1'b1; BTN = 16'($urandom);
        exp1 = model_word(PRESENT, BTN);
        got = '0; p0 = rx_pulses;
        do_latch(1'b0);
        read_bits(0, 10, $urandom, 1'b0, got);
        chk("t3_partial", got & 32'h3FF, exp1 & 32'h3FF);
        BTN = 16'($urandom);
        exp2 = model_word(PRESENT, BTN);
        di_w = $urandom;
        kp.KP_LATCH = 1'b1; kp.KP_CLK = 1'b1;
        tick(3);
        kp.KP_LATCH = 1'b0; kp.KP_CLK = 1'b0;
        tick(3);
        got = '0;
        read_bits(0, 32, di_w, 1'b0, got);
        chk("t3_word", got, exp2);
        chk("t3_busy_end", 32'(BUSY), 32'd0);
        chk_int("t3_rx_pulses", rx_pulses - p0, RX_EN ? 1 : 0);

        // Gap just under the timeout keeps the transfer alive.
        PRESENT = 1'b1; BTN = 16'($urandom);
        exp1 = model_word(PRESENT, BTN);
        di_w = $urandom;
        got = '0;
        do_latch(1'b0);
        read_bits(0, 5, di_w, 1'b0, got);
        tick(TIMEOUT_CYC - 2 - HOST_LOW);
        chk("t4_busy_gap", 32'(BUSY), 32'd1);
        read_bits(5, 27, di_w, 1'b0, got);
        chk("t4_word_gap", got, exp1);

        // A full timeout gap abandons the transfer.
        p0 = rx_pulses;
        got = '0;
        do_latch(1'b0);
        read_bits(0, 5, $urandom, 1'b0, got);
        chk("t4_partial", got & 32'h1F, exp1 & 32'h1F);
        tick(TIMEOUT_CYC);
        chk("t4_to_busy", 32'(BUSY),     32'd0);
        chk("t4_to_do",   32'(kp.KP_DO), 32'd1);
        chk_int("t4_to_rx", rx_pulses - p0, 0);

        // Reset in the middle of a word.
        p0 = rx_pulses;
        got = '0;
        do_latch(1'b0);
        read_bits(0, 17, $urandom, 1'b0, got);
        RES = 1'b1;
        tick(1);
        RES = 1'b0;
        tick(1);
        chk("t5_do",   32'(kp.KP_DO), 32'd1);
        chk("t5_busy", 32'(BUSY),     32'd0);
        chk_int("t5_rx", rx_pulses - p0, 0);
        PRESENT = 1'b1; BTN = 16'($urandom);
        xfer("t5_clean", $urandom, 1'b0, 1'b0);

        // With CE low the K-port pins are not sampled at all.
        PRESENT = 1'b1; BTN = 16'($urandom);
        exp1 = model_word(PRESENT, BTN);
        di_w = $urandom;
        got = '0;
        do_latch(1'b0);
        read_bits(0, 3, di_w, 1'b0, got);
        CE = 1'b0;
        kp.KP_CLK = 1'b1; kp.KP_LATCH = 1'b1;
        tick(3);
        kp.KP_CLK = 1'b0; kp.KP_LATCH = 1'b0;
        tick(3);
        CE = 1'b1;
        tick(2);
        read_bits(3, 29, di_w, 1'b0, got);
        chk("ce_word", got, exp1);

        PRESENT = 1'b1; BTN = 16'h0081;
        xfer("t6_rx", 32'hA5C3_0F1E, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
